// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V pipeline.
// Result-source encodings, M-stage FSM states and the M->W bundle.
package riscv_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mstate_t;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
    } mw_t;

endpackage

// File: rtl/memory_cycle.sv
// M stage: word load/store over a req/ack data port with timeout,
// pipeline stall while pending, and the M->W pipeline register.
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        MemErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RD_M_H,
    output logic        RegWriteM_H
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mstate_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mw_t           w_q, w_d;

    logic access;
    logic is_load;
    logic in_wait;
    logic timeout;
    logic stall;

    always_comb begin
        access  = MemWriteM | (ResultSrcM == RESULT_MEM);
        is_load = ~MemWriteM & (ResultSrcM == RESULT_MEM);
        in_wait = (state_q == M_WAIT);
        timeout = in_wait & (cnt_q == CNT_LAST) & ~dmem_ack;
        stall   = access & ~dmem_ack & ~timeout;
    end

    // Reset masks the handshake so an abandoned access cannot leak out.
    assign dmem_req    = ~rst & (access | in_wait);
    assign StallM      = ~rst & stall;
    assign MemErrM     = ~rst & timeout;
    assign dmem_we     = MemWriteM;
    assign dmem_addr   = {ALUResultM[31:2], 2'b00};
    assign dmem_wdata  = WriteDataM;
    assign RD_M_H      = RD_M;
    assign RegWriteM_H = RegWriteM;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            M_IDLE: begin
                if (access & ~dmem_ack) begin
                    state_d = M_WAIT;
                    cnt_d   = '0;
                end
            end
            M_WAIT: begin
                if (dmem_ack | timeout) begin
                    state_d = M_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Stall cycles push a bubble; timeout completes with zero load data.
    always_comb begin
        w_d = '0;
        if (!stall) begin
            w_d.regwrite  = RegWriteM;
            w_d.resultsrc = ResultSrcM;
            w_d.rd        = RD_M;
            w_d.alu       = ALUResultM;
            w_d.pc4       = PCPlus4M;
            w_d.rdata     = (is_load & dmem_ack) ? dmem_rdata : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= M_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    assign RegWriteW  = w_q.regwrite;
    assign ResultSrcW = w_q.resultsrc;
    assign RD_W       = w_q.rd;
    assign ALUResultW = w_q.alu;
    assign ReadDataW  = w_q.rdata;
    assign PCPlus4W   = w_q.pc4;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: vector table plus handshake,
// timeout and reset sequences.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        StallM;
    logic        MemErrM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RD_M_H;
    logic        RegWriteM_H;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .StallM(StallM), .MemErrM(MemErrM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RD_W(RD_W), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RD_M_H(RD_M_H), .RegWriteM_H(RegWriteM_H)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_stall;
        logic        e_rw;
        logic [1:0]  e_rs;
        logic [4:0]  e_rd;
        logic [31:0] e_alu;
        logic [31:0] e_rdw;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWriteM  = 1'b0;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        RD_M       = 5'd0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        PCPlus4M   = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic set_op(input logic rw, input logic mw, input logic [1:0] rs,
                          input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4);
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = rs;
        RD_M       = rd;
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc4;
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, "_rw"}, RegWriteW, 0);
        chk({tag, "_rs"}, ResultSrcW, 0);
        chk({tag, "_rd"}, RD_W, 0);
        chk({tag, "_alu"}, ALUResultW, 0);
        chk({tag, "_rdw"}, ReadDataW, 0);
        chk({tag, "_pc4"}, PCPlus4W, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalls;
        int bubbles;
        int errc;
        int early;

        vecs[0] = '{1'b1, 1'b0, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h8,
                    1'b0, 32'h0,
                    1'b0, 1'b0, 32'h1234, 1'b0,
                    1'b1, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h8};
        vecs[1] = '{1'b1, 1'b0, 2'b01, 5'd7, 32'h100, 32'h0, 32'h10,
                    1'b1, 32'hDEADBEEF,
                    1'b1, 1'b0, 32'h100, 1'b0,
                    1'b1, 2'b01, 5'd7, 32'h100, 32'hDEADBEEF, 32'h10};
        vecs[2] = '{1'b0, 1'b1, 2'b00, 5'd0, 32'h30, 32'h77, 32'h14,
                    1'b1, 32'h9999,
                    1'b1, 1'b1, 32'h30, 1'b0,
                    1'b0, 2'b00, 5'd0, 32'h30, 32'h0, 32'h14};
        vecs[3] = '{1'b1, 1'b0, 2'b10, 5'd1, 32'h44, 32'h0, 32'h2004,
                    1'b1, 32'hFFFF,
                    1'b0, 1'b0, 32'h44, 1'b0,
                    1'b1, 2'b10, 5'd1, 32'h44, 32'h0, 32'h2004};
        vecs[4] = '{1'b1, 1'b0, 2'b01, 5'd9, 32'h107, 32'h5, 32'h20,
                    1'b1, 32'h0BADF00D,
                    1'b1, 1'b0, 32'h104, 1'b0,
                    1'b1, 2'b01, 5'd9, 32'h107, 32'h0BADF00D, 32'h20};

        // Reset with an access presented: handshake masked, passthrough live.
        idle();
        rst = 1'b1;
        set_op(1'b1, 1'b1, 2'b00, 5'd17, 32'h80, 32'h1, 32'h4);
        tick();
        tick();
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_err", MemErrM, 0);
        chk("rst_rdh", RD_M_H, 17);
        chk("rst_rwh", RegWriteM_H, 1);
        chk_w_zero("rst_w");
        idle();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            set_op(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd,
                   vecs[i].alu, vecs[i].wd, vecs[i].pc4);
            dmem_ack   = vecs[i].ack;
            dmem_rdata = vecs[i].rdata;
            #2;
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
            chk($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
            chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wd);
            chk($sformatf("v%0d_stall", i), StallM, vecs[i].e_stall);
            chk($sformatf("v%0d_err", i), MemErrM, 0);
            chk($sformatf("v%0d_rdh", i), RD_M_H, vecs[i].rd);
            tick();
            chk($sformatf("v%0d_rww", i), RegWriteW, vecs[i].e_rw);
            chk($sformatf("v%0d_rsw", i), ResultSrcW, vecs[i].e_rs);
            chk($sformatf("v%0d_rdw", i), RD_W, vecs[i].e_rd);
            chk($sformatf("v%0d_aluw", i), ALUResultW, vecs[i].e_alu);
            chk($sformatf("v%0d_datw", i), ReadDataW, vecs[i].e_rdw);
            chk($sformatf("v%0d_pc4w", i), PCPlus4W, vecs[i].e_pc4);
        end
        idle();
        tick();

        // Store with ack on the fourth cycle: three stalls, three bubbles.
        set_op(1'b0, 1'b1, 2'b00, 5'd0, 32'h203, 32'hA5, 32'h40);
        stalls  = 0;
        bubbles = 0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("st_addr%0d", c), dmem_addr, 32'h200);
            chk($sformatf("st_req%0d", c), dmem_req, 1);
            if (StallM) stalls++;
            tick();
            if (ALUResultW == 0 && PCPlus4W == 0 && RegWriteW == 0)
                bubbles++;
        end
        dmem_ack = 1'b1;
        #2;
        chk("st_stall_ack", StallM, 0);
        chk("st_stalls", stalls, 3);
        chk("st_bubbles", bubbles, 3);
        tick();
        chk("st_aluw", ALUResultW, 32'h203);
        chk("st_pc4w", PCPlus4W, 32'h40);
        chk("st_datw", ReadDataW, 0);
        chk("st_rww", RegWriteW, 0);
        idle();
        tick();

        // Load never acked: IDLE cycle plus 15 WAIT cycles stall, abort on
        // the 16th WAIT cycle (17th cycle of the access).
        set_op(1'b1, 1'b0, 2'b01, 5'd3, 32'h400, 32'h0, 32'h500);
        dmem_rdata = 32'h1111;
        stalls = 0;
        errc   = 0;
        for (int c = 1; c <= 40; c++) begin
            #2;
            if (MemErrM) begin
                errc = c;
                chk("to_stall_on_err", StallM, 0);
                tick();
                break;
            end
            if (StallM) stalls++;
            tick();
        end
        chk("to_cycle", errc, 17);
        chk("to_stalls", stalls, 16);
        chk("to_datw", ReadDataW, 0);
        chk("to_rww", RegWriteW, 1);
        chk("to_rdw", RD_W, 3);
        chk("to_aluw", ALUResultW, 32'h400);
        idle();
        #2;
        chk("to_err_pulse", MemErrM, 0);
        chk("to_idle_req", dmem_req, 0);
        tick();

        // Reset during the second WAIT cycle abandons the access.
        set_op(1'b1, 1'b0, 2'b01, 5'd6, 32'h700, 32'h0, 32'h704);
        tick();
        tick();
        #1;
        chk("rw_wait_req", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rw_rst_req", dmem_req, 0);
        chk("rw_rst_stall", StallM, 0);
        tick();
        rst = 1'b0;
        idle();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE;
        chk_w_zero("rw_w");
        #2;
        chk("rw_late_req", dmem_req, 0);
        chk("rw_late_stall", StallM, 0);
        chk("rw_late_err", MemErrM, 0);
        tick();
        chk("rw_late_datw", ReadDataW, 0);
        idle();
        tick();

        // Ack arriving exactly on the timeout cycle completes normally.
        set_op(1'b1, 1'b0, 2'b01, 5'd4, 32'h600, 32'h0, 32'h604);
        early = 0;
        for (int c = 0; c < 16; c++) begin
            #2;
            if (MemErrM) early++;
            tick();
        end
        chk("ak_early_err", early, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55;
        #2;
        chk("ak_err", MemErrM, 0);
        chk("ak_stall", StallM, 0);
        tick();
        chk("ak_datw", ReadDataW, 32'h55);
        chk("ak_rww", RegWriteW, 1);
        chk("ak_rdw", RD_W, 4);
        idle();
        #2;
        chk("ak_idle_req", dmem_req, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
